// File: rtl/video_frame_mux.sv
`default_nettype none
// video_frame_mux: frame-synchronous 2:1 AXI4-Stream video selector (rev 1.0).
// Source switches land only on start-of-frame beats; the unselected source is always drained.
module video_frame_mux #(
  parameter int TDATA_WIDTH = 30,
  parameter int CNT_WIDTH   = 16,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 2,
  parameter int KEEP_WIDTH  = (TDATA_WIDTH + 7) / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   video0_tvalid_i,
  output logic                   video0_tready_o,
  input  logic [TDATA_WIDTH-1:0] video0_tdata_i,
  input  logic [KEEP_WIDTH-1:0]  video0_tstrb_i,
  input  logic [KEEP_WIDTH-1:0]  video0_tkeep_i,
  input  logic [TID_WIDTH-1:0]   video0_tid_i,
  input  logic [TDEST_WIDTH-1:0] video0_tdest_i,
  input  logic                   video0_tlast_i,
  input  logic                   video0_tuser_i,
  input  logic                   video1_tvalid_i,
  output logic                   video1_tready_o,
  input  logic [TDATA_WIDTH-1:0] video1_tdata_i,
  input  logic [KEEP_WIDTH-1:0]  video1_tstrb_i,
  input  logic [KEEP_WIDTH-1:0]  video1_tkeep_i,
  input  logic [TID_WIDTH-1:0]   video1_tid_i,
  input  logic [TDEST_WIDTH-1:0] video1_tdest_i,
  input  logic                   video1_tlast_i,
  input  logic                   video1_tuser_i,
  output logic                   video_tvalid_o,
  input  logic                   video_tready_i,
  output logic [TDATA_WIDTH-1:0] video_tdata_o,
  output logic [KEEP_WIDTH-1:0]  video_tstrb_o,
  output logic [KEEP_WIDTH-1:0]  video_tkeep_o,
  output logic [TID_WIDTH-1:0]   video_tid_o,
  output logic [TDEST_WIDTH-1:0] video_tdest_o,
  output logic                   video_tlast_o,
  output logic                   video_tuser_o,
  input  logic                   sel_i,
  output logic                   active_src_o,
  output logic                   locked_o,
  output logic [CNT_WIDTH-1:0]   frame_cnt_o
);

  typedef enum logic [0:0] {WAIT_SOF = 1'b0, PASS = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   active_src_q, active_src_d;
  logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic                   out_tvalid_q, out_tvalid_d;
  logic                   out_tlast_q, out_tlast_d;
  logic                   out_tuser_q, out_tuser_d;
  logic [TDATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic [KEEP_WIDTH-1:0]  out_tstrb_q, out_tstrb_d;
  logic [KEEP_WIDTH-1:0]  out_tkeep_q, out_tkeep_d;
  logic [TID_WIDTH-1:0]   out_tid_q, out_tid_d;
  logic [TDEST_WIDTH-1:0] out_tdest_q, out_tdest_d;

  logic                   s_tvalid, s_tlast, s_tuser, s_tready;
  logic [TDATA_WIDTH-1:0] s_tdata;
  logic [KEEP_WIDTH-1:0]  s_tstrb, s_tkeep;
  logic [TID_WIDTH-1:0]   s_tid;
  logic [TDEST_WIDTH-1:0] s_tdest;
  logic                   out_rdy, load;

  always_comb begin
    if (active_src_q) begin
      s_tvalid = video1_tvalid_i; s_tdata = video1_tdata_i; s_tstrb = video1_tstrb_i;
      s_tkeep  = video1_tkeep_i;  s_tid   = video1_tid_i;   s_tdest = video1_tdest_i;
      s_tlast  = video1_tlast_i;  s_tuser = video1_tuser_i;
    end else begin
      s_tvalid = video0_tvalid_i; s_tdata = video0_tdata_i; s_tstrb = video0_tstrb_i;
      s_tkeep  = video0_tkeep_i;  s_tid   = video0_tid_i;   s_tdest = video0_tdest_i;
      s_tlast  = video0_tlast_i;  s_tuser = video0_tuser_i;
    end
  end

  always_comb begin
    out_rdy      = !out_tvalid_q || video_tready_i;
    state_d      = state_q;
    active_src_d = active_src_q;
    s_tready     = out_rdy;
    load         = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        // Non-SOF beats are swallowed; only an SOF waits on the output stage.
        s_tready = (s_tvalid && s_tuser) ? out_rdy : 1'b1;
        load     = s_tvalid && s_tuser && out_rdy;
        if (load) state_d = PASS;
        else      active_src_d = sel_i;
      end
      PASS: begin
        if (s_tvalid && s_tuser && (sel_i != active_src_q)) begin
          // Hold the new frame's SOF back and hand ownership over immediately.
          s_tready     = 1'b0;
          state_d      = WAIT_SOF;
          active_src_d = sel_i;
        end else begin
          load = s_tvalid && out_rdy;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_comb begin
    out_tvalid_d = out_tvalid_q;
    out_tlast_d  = out_tlast_q;
    out_tuser_d  = out_tuser_q;
    out_tdata_d  = out_tdata_q;
    out_tstrb_d  = out_tstrb_q;
    out_tkeep_d  = out_tkeep_q;
    out_tid_d    = out_tid_q;
    out_tdest_d  = out_tdest_q;
    frame_cnt_d  = frame_cnt_q;
    if (out_rdy) out_tvalid_d = load;
    if (load) begin
      out_tlast_d = s_tlast; out_tuser_d = s_tuser; out_tdata_d = s_tdata;
      out_tstrb_d = s_tstrb; out_tkeep_d = s_tkeep; out_tid_d   = s_tid;
      out_tdest_d = s_tdest;
      if (s_tuser) frame_cnt_d = frame_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= WAIT_SOF;
      active_src_q <= 1'b0;
      frame_cnt_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= 1'b0;
      out_tdata_q  <= '0;
      out_tstrb_q  <= '0;
      out_tkeep_q  <= '0;
      out_tid_q    <= '0;
      out_tdest_q  <= '0;
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      frame_cnt_q  <= frame_cnt_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
      out_tuser_q  <= out_tuser_d;
      out_tdata_q  <= out_tdata_d;
      out_tstrb_q  <= out_tstrb_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tid_q    <= out_tid_d;
      out_tdest_q  <= out_tdest_d;
    end
  end

  assign video0_tready_o = active_src_q ? 1'b1 : s_tready;
  assign video1_tready_o = active_src_q ? s_tready : 1'b1;
  assign video_tvalid_o  = out_tvalid_q;
  assign video_tdata_o   = out_tdata_q;
  assign video_tstrb_o   = out_tstrb_q;
  assign video_tkeep_o   = out_tkeep_q;
  assign video_tid_o     = out_tid_q;
  assign video_tdest_o   = out_tdest_q;
  assign video_tlast_o   = out_tlast_q;
  assign video_tuser_o   = out_tuser_q;
  assign active_src_o    = active_src_q;
  assign locked_o        = (state_q == PASS);
  assign frame_cnt_o     = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_mux.sv
`default_nettype none
// tb_video_frame_mux: directed vector table plus hand-written reset, wrap and backpressure sequences.
module tb_video_frame_mux;

  localparam int DW = 30;
  localparam logic [2:0] IDLE = 3'b000, NS = 3'b100, NSL = 3'b101, SOF = 3'b110, SOFL = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic v0_tvalid, v0_tlast, v0_tuser, v1_tvalid, v1_tlast, v1_tuser;
  logic [DW-1:0] v0_tdata, v1_tdata;
  logic [3:0] v0_tstrb, v0_tkeep, v1_tstrb, v1_tkeep;
  logic [1:0] v0_tid, v0_tdest, v1_tid, v1_tdest;
  logic v0_tready, v1_tready;
  logic o_tvalid, o_tready, o_tlast, o_tuser;
  logic [DW-1:0] o_tdata;
  logic [3:0] o_tstrb, o_tkeep;
  logic [1:0] o_tid, o_tdest;
  logic active_src, locked;
  logic [1:0] frame_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  video_frame_mux #(.TDATA_WIDTH(DW), .CNT_WIDTH(2), .TID_WIDTH(2), .TDEST_WIDTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .video0_tvalid_i(v0_tvalid), .video0_tready_o(v0_tready), .video0_tdata_i(v0_tdata),
    .video0_tstrb_i(v0_tstrb), .video0_tkeep_i(v0_tkeep), .video0_tid_i(v0_tid),
    .video0_tdest_i(v0_tdest), .video0_tlast_i(v0_tlast), .video0_tuser_i(v0_tuser),
    .video1_tvalid_i(v1_tvalid), .video1_tready_o(v1_tready), .video1_tdata_i(v1_tdata),
    .video1_tstrb_i(v1_tstrb), .video1_tkeep_i(v1_tkeep), .video1_tid_i(v1_tid),
    .video1_tdest_i(v1_tdest), .video1_tlast_i(v1_tlast), .video1_tuser_i(v1_tuser),
    .video_tvalid_o(o_tvalid), .video_tready_i(o_tready), .video_tdata_o(o_tdata),
    .video_tstrb_o(o_tstrb), .video_tkeep_o(o_tkeep), .video_tid_o(o_tid),
    .video_tdest_o(o_tdest), .video_tlast_o(o_tlast), .video_tuser_o(o_tuser),
    .sel_i(sel), .active_src_o(active_src), .locked_o(locked), .frame_cnt_o(frame_cnt)
  );

  typedef struct {
    logic          sel;
    logic [2:0]    b0;
    logic [DW-1:0] d0;
    logic [2:0]    b1;
    logic [DW-1:0] d1;
    logic          r0, r1, ov;
    logic [1:0]    oul;
    logic [DW-1:0] od;
    logic          osrc, lk, act;
    logic [1:0]    cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic [2:0] b0, input logic [DW-1:0] d0,
                     input logic [2:0] b1, input logic [DW-1:0] d1, input logic r0,
                     input logic r1, input logic ov, input logic [1:0] oul,
                     input logic [DW-1:0] od, input logic osrc, input logic lk,
                     input logic act, input logic [1:0] cnt);
    vec_t v;
    v.sel = s; v.b0 = b0; v.d0 = d0; v.b1 = b1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
    v.ov = ov; v.oul = oul; v.od = od; v.osrc = osrc; v.lk = lk; v.act = act; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] b0, input logic [DW-1:0] d0,
                       input logic [2:0] b1, input logic [DW-1:0] d1);
    sel = s;
    v0_tvalid = b0[2]; v0_tuser = b0[1]; v0_tlast = b0[0]; v0_tdata = d0;
    v1_tvalid = b1[2]; v1_tuser = b1[1]; v1_tlast = b1[0]; v1_tdata = d1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, IDLE, '0, IDLE, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] wrap_exp [5];
    vec_t v;
    int rx, tx, cyc;
    logic held;
    logic [DW-1:0] held_d;

    v0_tid = 2'd0; v0_tdest = 2'd2; v0_tstrb = 4'h5; v0_tkeep = 4'hF;
    v1_tid = 2'd1; v1_tdest = 2'd3; v1_tstrb = 4'hA; v1_tkeep = 4'h7;
    drive(1'b0, IDLE, '0, IDLE, '0);
    o_tready = 1'b1;

    // Lock onto src1, switch to src0 mid-frame, then sel toggle coinciding with an accepted SOF.
    add(1, IDLE, 0, NS,   'h1F1, 1, 1, 0, 2'b00, 0,     0, 0, 0, 0);
    add(1, IDLE, 0, NS,   'h1F2, 1, 1, 0, 2'b00, 0,     0, 0, 1, 0);
    add(1, IDLE, 0, NS,   'h1F3, 1, 1, 0, 2'b00, 0,     0, 0, 1, 0);
    add(1, IDLE, 0, SOF,  'h100, 1, 1, 0, 2'b00, 0,     0, 0, 1, 0);
    add(1, IDLE, 0, NS,   'h101, 1, 1, 1, 2'b10, 'h100, 1, 1, 1, 1);
    add(1, IDLE, 0, NS,   'h102, 1, 1, 1, 2'b00, 'h101, 1, 1, 1, 1);
    add(1, IDLE, 0, NSL,  'h103, 1, 1, 1, 2'b00, 'h102, 1, 1, 1, 1);
    add(1, IDLE, 0, NS,   'h104, 1, 1, 1, 2'b01, 'h103, 1, 1, 1, 1);
    add(0, IDLE, 0, NS,   'h105, 1, 1, 1, 2'b00, 'h104, 1, 1, 1, 1);
    add(0, IDLE, 0, NS,   'h106, 1, 1, 1, 2'b00, 'h105, 1, 1, 1, 1);
    add(0, IDLE, 0, NSL,  'h107, 1, 1, 1, 2'b00, 'h106, 1, 1, 1, 1);
    add(0, IDLE, 0, IDLE, 0,     1, 1, 1, 2'b01, 'h107, 1, 1, 1, 1);
    add(0, NS, 'h2F0, SOF,  'h110, 1, 0, 0, 2'b00, 0,     0, 1, 1, 1);
    add(0, SOF, 'h200, SOF, 'h110, 1, 1, 0, 2'b00, 0,     0, 0, 0, 1);
    add(0, NS,  'h201, IDLE, 0,    1, 1, 1, 2'b10, 'h200, 0, 1, 0, 2);
    add(0, NSL, 'h202, IDLE, 0,    1, 1, 1, 2'b00, 'h201, 0, 1, 0, 2);
    add(0, IDLE, 0,    IDLE, 0,    1, 1, 1, 2'b01, 'h202, 0, 1, 0, 2);
    add(0, IDLE, 0,    IDLE, 0,    1, 1, 0, 2'b00, 0,     0, 1, 0, 2);
    add(1, SOF, 'h210, IDLE, 0,    0, 1, 0, 2'b00, 0,     0, 1, 0, 2);
    add(1, SOF, 'h210, IDLE, 0,    1, 1, 0, 2'b00, 0,     0, 0, 1, 2);
    add(0, IDLE, 0,    SOF, 'h120, 1, 1, 0, 2'b00, 0,     0, 0, 1, 2);
    add(0, IDLE, 0,    NSL, 'h121, 1, 1, 1, 2'b10, 'h120, 1, 1, 1, 3);
    add(0, IDLE, 0,    SOF, 'h130, 1, 0, 1, 2'b01, 'h121, 1, 1, 1, 3);
    add(0, IDLE, 0,    SOF, 'h130, 1, 1, 0, 2'b00, 0,     0, 0, 0, 3);

    // Power-on reset state.
    #2 rst = 1'b1;
    #1;
    chk("por tvalid", 32'(o_tvalid), 32'd0);
    chk("por cnt", 32'(frame_cnt), 32'd0);
    chk("por locked", 32'(locked), 32'd0);
    chk("por active", 32'(active_src), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.sel, v.b0, v.d0, v.b1, v.d1);
      #1;
      chk($sformatf("v%0d r0", i), 32'(v0_tready), 32'(v.r0));
      chk($sformatf("v%0d r1", i), 32'(v1_tready), 32'(v.r1));
      chk($sformatf("v%0d tvalid", i), 32'(o_tvalid), 32'(v.ov));
      chk($sformatf("v%0d locked", i), 32'(locked), 32'(v.lk));
      chk($sformatf("v%0d active", i), 32'(active_src), 32'(v.act));
      chk($sformatf("v%0d cnt", i), 32'(frame_cnt), 32'(v.cnt));
      if (v.ov) begin
        chk($sformatf("v%0d tdata", i), 32'(o_tdata), 32'(v.od));
        chk($sformatf("v%0d tuser/tlast", i), 32'({o_tuser, o_tlast}), 32'(v.oul));
        chk($sformatf("v%0d tid", i), 32'(o_tid), 32'(v.osrc));
        chk($sformatf("v%0d tdest", i), 32'(o_tdest), v.osrc ? 32'd3 : 32'd2);
        chk($sformatf("v%0d tstrb", i), 32'(o_tstrb), v.osrc ? 32'hA : 32'h5);
        chk($sformatf("v%0d tkeep", i), 32'(o_tkeep), v.osrc ? 32'h7 : 32'hF);
      end
    end

    // Reset asserted in the middle of an output beat, then no partial frame after release.
    @(negedge clk); drive(1'b0, SOF, 'h220, IDLE, '0);
    @(negedge clk); drive(1'b0, NS, 'h221, IDLE, '0);
    #1 chk("mid pre tvalid", 32'(o_tvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid tvalid", 32'(o_tvalid), 32'd0);
    chk("mid tdata", 32'(o_tdata), 32'd0);
    chk("mid tuser", 32'(o_tuser), 32'd0);
    chk("mid tlast", 32'(o_tlast), 32'd0);
    chk("mid tstrb/tkeep", 32'({o_tstrb, o_tkeep}), 32'd0);
    chk("mid tid/tdest", 32'({o_tid, o_tdest}), 32'd0);
    chk("mid cnt", 32'(frame_cnt), 32'd0);
    chk("mid active", 32'(active_src), 32'd0);
    chk("mid locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1'b0, NS, 30'h222 + 30'(k), IDLE, '0);
      #1 chk($sformatf("post-rst drop%0d", k), 32'({o_tvalid, locked}), 32'd0);
    end
    @(negedge clk); drive(1'b0, SOF, 'h230, IDLE, '0);
    @(negedge clk); drive(1'b0, IDLE, '0, IDLE, '0);
    #1;
    chk("post-rst sof valid/user", 32'({o_tvalid, o_tuser}), 32'd3);
    chk("post-rst sof data", 32'(o_tdata), 32'h230);
    chk("post-rst cnt", 32'(frame_cnt), 32'd1);

    // Counter wrap with a 2-bit counter.
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0;
    wrap_exp[4] = 2'd1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(1'b0, SOFL, 30'h240 + 30'(k), IDLE, '0);
      @(negedge clk); drive(1'b0, IDLE, '0, IDLE, '0);
      #1;
      chk($sformatf("wrap%0d valid", k), 32'(o_tvalid), 32'd1);
      chk($sformatf("wrap%0d cnt", k), 32'(frame_cnt), 32'(wrap_exp[k]));
    end

    // Random output backpressure over a 4x2 frame from src0; src1 keeps pushing junk.
    do_reset();
    rx = 0; tx = 0; cyc = 0; held = 1'b0; held_d = '0;
    while (rx < 8 && cyc < 200) begin
      @(negedge clk);
      o_tready = 1'($urandom_range(0, 1));
      if (tx < 8)
        drive(1'b0, {1'b1, tx == 0, tx == 3 || tx == 7}, 30'h300 + 30'(tx), NS, 'h3FF);
      else
        drive(1'b0, IDLE, '0, NS, 'h3FF);
      #1;
      chk($sformatf("bp%0d unsel ready", cyc), 32'(v1_tready), 32'd1);
      if (held) begin
        chk($sformatf("bp%0d stall valid", cyc), 32'(o_tvalid), 32'd1);
        chk($sformatf("bp%0d stall data", cyc), 32'(o_tdata), 32'(held_d));
      end
      if (o_tvalid && o_tready) begin
        chk($sformatf("bp rx%0d data", rx), 32'(o_tdata), 32'h300 + 32'(rx));
        chk($sformatf("bp rx%0d user", rx), 32'(o_tuser), 32'(rx == 0));
        chk($sformatf("bp rx%0d last", rx), 32'(o_tlast), 32'(rx == 3 || rx == 7));
        rx++;
      end
      held = o_tvalid && !o_tready;
      held_d = o_tdata;
      if (tx < 8 && v0_tready) tx++;
      cyc++;
    end
    chk("bp beats received", 32'(rx), 32'd8);
    @(negedge clk); o_tready = 1'b1; drive(1'b0, IDLE, '0, IDLE, '0);
    #1 chk("bp cnt", 32'(frame_cnt), 32'd1);
    @(negedge clk);
    #1 chk("bp no extra beat", 32'(o_tvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
